jacobi_pair_sched: RTL and testbench

JACOBI_PAIR_SCHED -- requirements
Module: jacobi_pair_sched

---
 rtl/jacobi_pair_sched_if.sv | 37 +++
 rtl/jacobi_pair_sched.sv | 179 +++++++++++++++++
 tb/tb_jacobi_pair_sched.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jacobi_pair_sched_if.sv
// Handshake bundle between the Jacobi pair scheduler and its environment:
// run control, covariance read strobe, arctangent return path and tagged results.
interface jacobi_pair_sched_if #(
  parameter int IDXW = 4
);
  logic            start;
  logic [3:0]      num_sweeps;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [IDXW-1:0] rd_p;
  logic [IDXW-1:0] rd_q;
  logic            arc_in_valid;
  logic            arc_out_valid;
  logic [7:0]      arc_data;
  logic            res_valid;
  logic [IDXW-1:0] res_p;
  logic [IDXW-1:0] res_q;
  logic [7:0]      res_angle;
  logic            res_ack;
  logic [3:0]      sweep_idx;
  logic            err;

  // Scheduler side
  modport master (
    input  start, num_sweeps, arc_out_valid, arc_data, res_ack,
    output busy, done, rd_en, rd_p, rd_q, arc_in_valid,
           res_valid, res_p, res_q, res_angle, sweep_idx, err
  );

  // Environment side (host, covariance memory, inv_tan, rotation stage)
  modport slave (
    output start, num_sweeps, arc_out_valid, arc_data, res_ack,
    input  busy, done, rd_en, rd_p, rd_q, arc_in_valid,
           res_valid, res_p, res_q, res_angle, sweep_idx, err
  );
endinterface

// File: rtl/jacobi_pair_sched.sv
// Jacobi pair scheduler: walks the upper-triangle (p,q) pairs row-cyclically,
// issues covariance reads under a downstream credit limit, tags each read
// through the arctangent latency and emits tagged rotation angles.
module jacobi_pair_sched #(
  parameter int N       = 4,
  parameter int LATENCY = 13,
  parameter int CREDITS = 4,
  parameter int IDXW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jacobi_pair_sched_if.master  bus
);

  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t          r_state;
  state_t          w_stateNext;

  logic [CW-1:0]   r_credit;
  logic [CW-1:0]   r_outst;
  logic [IDXW-1:0] r_p;
  logic [IDXW-1:0] r_q;
  logic [3:0]      r_sweep;
  logic [3:0]      r_numSweeps;
  logic            r_arcInValid;
  logic            r_resValid;
  logic [IDXW-1:0] r_resP;
  logic [IDXW-1:0] r_resQ;
  logic [7:0]      r_resAngle;
  logic            r_err;

  logic            r_tagV [LATENCY];
  logic [IDXW-1:0] r_tagP [LATENCY];
  logic [IDXW-1:0] r_tagQ [LATENCY];

  logic            w_accept;
  logic            w_issue;
  logic            w_lastPair;
  logic            w_ackOk;
  logic            w_tailV;
  logic            w_resLoad;
  logic            w_mismatch;
  logic            w_drained;
  logic            w_more;
  logic            w_arcDec;

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_issue    = (r_state == S_ISSUE) && (r_credit != '0);
  assign w_lastPair = (r_p == IDXW'(N - 2)) && (r_q == IDXW'(N - 1));
  assign w_ackOk    = bus.res_ack && (r_state != S_IDLE) && (r_credit != CW'(CREDITS));
  assign w_tailV    = r_tagV[LATENCY-1];
  assign w_resLoad  = bus.arc_out_valid && w_tailV;
  assign w_mismatch = bus.arc_out_valid != w_tailV;
  assign w_drained  = (r_outst == '0) && (r_credit == CW'(CREDITS));
  assign w_more     = (5'(r_sweep) + 5'd1) < 5'(r_numSweeps);
  assign w_arcDec   = bus.arc_out_valid && (r_outst != '0);

  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = (r_state == S_FINISH);
  assign bus.rd_en        = w_issue;
  assign bus.rd_p         = r_p;
  assign bus.rd_q         = r_q;
  assign bus.arc_in_valid = r_arcInValid;
  assign bus.res_valid    = r_resValid;
  assign bus.res_p        = r_resP;
  assign bus.res_q        = r_resQ;
  assign bus.res_angle    = r_resAngle;
  assign bus.sweep_idx    = r_sweep;
  assign bus.err          = r_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state selection: issue a sweep, drain it, repeat or finish
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_stateNext = S_ISSUE;
      S_ISSUE:  if (w_issue && w_lastPair) w_stateNext = S_WAIT;
      S_WAIT:   if (w_drained) w_stateNext = w_more ? S_ISSUE : S_FINISH;
      S_FINISH: w_stateNext = S_IDLE;
      default:  w_stateNext = S_IDLE;
    endcase
  end

  // Run bookkeeping: sweep count, sweep index and the row-cyclic pair walker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_numSweeps <= 4'd1;
      r_sweep     <= 4'd0;
      r_p         <= '0;
      r_q         <= IDXW'(1);
    end else if (w_accept) begin
      r_numSweeps <= (bus.num_sweeps == 4'd0) ? 4'd1 : bus.num_sweeps;
      r_sweep     <= 4'd0;
      r_p         <= '0;
      r_q         <= IDXW'(1);
    end else if (w_issue && !w_lastPair) begin
      if (r_q == IDXW'(N - 1)) begin
        r_p <= r_p + IDXW'(1);
        r_q <= r_p + IDXW'(2);
      end else begin
        r_q <= r_q + IDXW'(1);
      end
    end else if ((r_state == S_WAIT) && w_drained && w_more) begin
      r_sweep <= r_sweep + 4'd1;
      r_p     <= '0;
      r_q     <= IDXW'(1);
    end
  end

  // Credit and outstanding counters; simultaneous up/down cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit <= CW'(CREDITS);
      r_outst  <= '0;
    end else begin
      case ({w_issue, w_ackOk})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01:   r_credit <= r_credit + CW'(1);
        default: r_credit <= r_credit;
      endcase
      case ({w_issue, w_arcDec})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Tag pipe tracking each read through the arctangent latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_tagV[i] <= 1'b0;
        r_tagP[i] <= '0;
        r_tagQ[i] <= '0;
      end
    end else begin
      r_tagV[0] <= w_issue;
      r_tagP[0] <= r_p;
      r_tagQ[0] <= r_q;
      for (int i = 1; i < LATENCY; i++) begin
        r_tagV[i] <= r_tagV[i-1];
        r_tagP[i] <= r_tagP[i-1];
        r_tagQ[i] <= r_tagQ[i-1];
      end
    end
  end

  // Result register, arctangent-valid delay and sticky tag-mismatch flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arcInValid <= 1'b0;
      r_resValid   <= 1'b0;
      r_resP       <= '0;
      r_resQ       <= '0;
      r_resAngle   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_arcInValid <= w_issue;
      r_resValid   <= w_resLoad;
      if (w_resLoad) begin
        r_resP     <= r_tagP[LATENCY-1];
        r_resQ     <= r_tagQ[LATENCY-1];
        r_resAngle <= bus.arc_data;
      end
      if (w_mismatch)    r_err <= 1'b1;
      else if (w_accept) r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jacobi_pair_sched.sv
// Self-checking bench for jacobi_pair_sched: models the covariance read /
// inv_tan / rotation-stage environment and checks pair order, result tags,
// latency, credit flow, sweeps, error flag and reset behaviour.
module tb_jacobi_pair_sched;

  localparam int N       = 4;
  localparam int LATENCY = 13;
  localparam int CREDITS = 4;
  localparam int IDXW    = 4;
  localparam int NPAIRS  = N * (N - 1) / 2;
  localparam int BIGACK  = 1000000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  jacobi_pair_sched_if #(.IDXW(IDXW)) bus ();

  jacobi_pair_sched #(
    .N(N), .LATENCY(LATENCY), .CREDITS(CREDITS), .IDXW(IDXW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { int sweep; int p; int q; } pair_t;
  typedef struct { int t; int p; int q; } issue_t;
  typedef struct { int due; logic [7:0] data; } arc_t;

  pair_t      expPairs[$];
  issue_t     issueQ[$];
  arc_t       arcQ[$];
  logic [7:0] angleQ[$];

  int cyc, vectors, miscompares;
  int issuedCnt, ackCnt, resCnt, doneCnt;
  int ackPending, ackAllow, lastAckCycle, lastIssueCycle, maxSweepSeen;
  bit startReq, spurReq;
  logic [3:0] nsReq;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected pair sequence for a run, straight from the row-cyclic ordering rule
  task automatic fillPairs(input int ns);
    int eff;
    eff = (ns == 0) ? 1 : ns;
    for (int s = 0; s < eff; s++)
      for (int p = 0; p < N - 1; p++)
        for (int q = p + 1; q < N; q++)
          expPairs.push_back('{s, p, q});
  endtask

  task automatic observeCycle();
    pair_t ep;
    issue_t ir;
    logic [7:0] d;
    if (!rst_n) return;
    if (bus.arc_in_valid) begin
      d = 8'($urandom);
      arcQ.push_back('{cyc + 12, d});
      angleQ.push_back(d);
    end
    if (bus.rd_en) begin
      checkOutput("credit_avail", 32'((issuedCnt - ackCnt) < CREDITS), 32'd1);
      if (expPairs.size() == 0) begin
        checkOutput("unexpected_issue", 32'd1, 32'd0);
      end else begin
        ep = expPairs.pop_front();
        checkOutput("rd_p", 32'(bus.rd_p), 32'(ep.p));
        checkOutput("rd_q", 32'(bus.rd_q), 32'(ep.q));
        checkOutput("sweep_idx", 32'(bus.sweep_idx), 32'(ep.sweep));
        if (ep.sweep > 0 && ep.p == 0 && ep.q == 1)
          checkOutput("wait_drained", 32'(ackCnt), 32'(issuedCnt));
        if (ep.sweep > maxSweepSeen) maxSweepSeen = ep.sweep;
      end
      issueQ.push_back('{cyc, int'(bus.rd_p), int'(bus.rd_q)});
      issuedCnt++;
      lastIssueCycle = cyc;
    end
    if (bus.res_valid) begin
      if (issueQ.size() == 0 || angleQ.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        ir = issueQ.pop_front();
        d  = angleQ.pop_front();
        checkOutput("res_latency", 32'(cyc - ir.t), 32'd14);
        checkOutput("res_p", 32'(bus.res_p), 32'(ir.p));
        checkOutput("res_q", 32'(bus.res_q), 32'(ir.q));
        checkOutput("res_angle", 32'(bus.res_angle), 32'(d));
      end
      resCnt++;
      ackPending++;
    end
    if (bus.done) doneCnt++;
  endtask

  task automatic applyStimulus();
    bus.start      = startReq;
    startReq       = 1'b0;
    bus.num_sweeps = nsReq;
    if (arcQ.size() > 0 && arcQ[0].due == cyc) begin
      bus.arc_out_valid = 1'b1;
      bus.arc_data      = arcQ[0].data;
      void'(arcQ.pop_front());
    end else begin
      bus.arc_out_valid = 1'b0;
      bus.arc_data      = 8'($urandom);
    end
    if (spurReq) bus.arc_out_valid = 1'b1;
    spurReq = 1'b0;
  endtask

  task automatic tick();
    bit ackNow;
    @(negedge clk);
    cyc++;
    ackNow = 1'b0;
    if (rst_n && ackPending > 0 && ackAllow > 0) begin
      ackNow = 1'b1;
      ackPending--;
      ackAllow--;
      lastAckCycle = cyc;
    end
    bus.res_ack = ackNow;
    observeCycle();
    if (ackNow) ackCnt++;
    applyStimulus();
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic waitDone(input int limit);
    int d0, k;
    d0 = doneCnt;
    k  = 0;
    while (doneCnt == d0 && k < limit) begin
      tick();
      k++;
    end
    checkOutput("done_seen", 32'(doneCnt - d0), 32'd1);
    tickN(3);
    checkOutput("done_once", 32'(doneCnt - d0), 32'd1);
    checkOutput("idle_after_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},   32'(bus.busy), 32'd0);
    checkOutput({tag, "_done"},   32'(bus.done), 32'd0);
    checkOutput({tag, "_rd_en"},  32'(bus.rd_en), 32'd0);
    checkOutput({tag, "_arcin"},  32'(bus.arc_in_valid), 32'd0);
    checkOutput({tag, "_resv"},   32'(bus.res_valid), 32'd0);
    checkOutput({tag, "_err"},    32'(bus.err), 32'd0);
    checkOutput({tag, "_rd_p"},   32'(bus.rd_p), 32'd0);
    checkOutput({tag, "_rd_q"},   32'(bus.rd_q), 32'd1);
    checkOutput({tag, "_sweep"},  32'(bus.sweep_idx), 32'd0);
  endtask

  initial begin
    int i0, r0, k;
    vectors = 0; miscompares = 0; cyc = 0;
    issuedCnt = 0; ackCnt = 0; resCnt = 0; doneCnt = 0;
    ackPending = 0; ackAllow = BIGACK; lastAckCycle = -10; lastIssueCycle = -10;
    maxSweepSeen = 0; startReq = 1'b0; spurReq = 1'b0; nsReq = 4'd1;
    bus.start = 1'b0; bus.num_sweeps = 4'd1; bus.arc_out_valid = 1'b0;
    bus.arc_data = 8'd0; bus.res_ack = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tickN(2);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tickN(2);

    // Single sweep with prompt acknowledgements
    $display("[TB] single sweep");
    i0 = issuedCnt; r0 = resCnt;
    fillPairs(1); nsReq = 4'd1; startReq = 1'b1;
    tick();
    tick();
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    waitDone(500);
    checkOutput("s1_issued", 32'(issuedCnt - i0), 32'(NPAIRS));
    checkOutput("s1_results", 32'(resCnt - r0), 32'(NPAIRS));
    checkOutput("s1_pairs_left", 32'(expPairs.size()), 32'd0);
    checkOutput("s1_err", 32'(bus.err), 32'd0);

    // Credit stall: no acknowledgements, then release exactly one
    $display("[TB] credit stall");
    ackAllow = 0;
    i0 = issuedCnt; r0 = resCnt;
    fillPairs(1); nsReq = 4'd1; startReq = 1'b1;
    tickN(30);
    checkOutput("stall_issued", 32'(issuedCnt - i0), 32'(CREDITS));
    checkOutput("stall_results", 32'(resCnt - r0), 32'(CREDITS));
    ackAllow = 1;
    tickN(4);
    checkOutput("one_more_issue", 32'(issuedCnt - i0), 32'(CREDITS + 1));
    checkOutput("issue_after_ack", 32'(lastIssueCycle), 32'(lastAckCycle + 1));
    ackAllow = BIGACK;
    waitDone(500);
    checkOutput("stall_total", 32'(issuedCnt - i0), 32'(NPAIRS));

    // Three sweeps
    $display("[TB] three sweeps");
    i0 = issuedCnt; r0 = resCnt; maxSweepSeen = 0;
    fillPairs(3); nsReq = 4'd3; startReq = 1'b1;
    waitDone(1500);
    checkOutput("s3_issued", 32'(issuedCnt - i0), 32'(3 * NPAIRS));
    checkOutput("s3_results", 32'(resCnt - r0), 32'(3 * NPAIRS));
    checkOutput("s3_max_sweep", 32'(maxSweepSeen), 32'd2);
    checkOutput("s3_err", 32'(bus.err), 32'd0);

    // Zero sweeps behaves as one; a start while busy is ignored
    $display("[TB] zero sweeps and start while busy");
    i0 = issuedCnt;
    fillPairs(0); nsReq = 4'd0; startReq = 1'b1;
    tickN(3);
    nsReq = 4'd3; startReq = 1'b1;
    waitDone(500);
    tickN(20);
    checkOutput("s0_issued", 32'(issuedCnt - i0), 32'(NPAIRS));
    checkOutput("s0_still_idle", 32'(bus.busy), 32'd0);

    // Spurious arctangent result with an empty tag pipe
    $display("[TB] spurious arctangent result");
    r0 = resCnt;
    spurReq = 1'b1;
    tickN(2);
    checkOutput("spur_err", 32'(bus.err), 32'd1);
    tickN(5);
    checkOutput("spur_err_sticky", 32'(bus.err), 32'd1);
    checkOutput("spur_no_result", 32'(resCnt - r0), 32'd0);
    i0 = issuedCnt;
    fillPairs(1); nsReq = 4'(1 + $urandom_range(0, 1)); 
    if (nsReq == 4'd2) fillPairs(1);
    startReq = 1'b1;
    tickN(2);
    checkOutput("spur_err_cleared", 32'(bus.err), 32'd0);
    waitDone(1000);
    checkOutput("spur_run_err", 32'(bus.err), 32'd0);

    // Reset with results in flight
    $display("[TB] reset mid-run");
    ackAllow = 0;
    i0 = issuedCnt;
    fillPairs(1); nsReq = 4'd1; startReq = 1'b1;
    k = 0;
    while ((issuedCnt - i0) < 3 && k < 50) begin
      tick();
      k++;
    end
    checkOutput("pre_reset_issued", 32'(issuedCnt - i0), 32'd3);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    tickN(2);
    expPairs.delete(); issueQ.delete(); angleQ.delete();
    ackPending = 0; issuedCnt = 0; ackCnt = 0;
    rst_n = 1'b1;
    tickN(20);
    checkOutput("stray_arc_err", 32'(bus.err), 32'd1);
    r0 = resCnt;
    fillPairs(1); nsReq = 4'd1; startReq = 1'b1;
    tickN(30);
    checkOutput("post_reset_credit", 32'(issuedCnt), 32'(CREDITS));
    checkOutput("post_reset_err", 32'(bus.err), 32'd0);
    ackAllow = BIGACK;
    waitDone(500);
    checkOutput("post_reset_issued", 32'(issuedCnt), 32'(NPAIRS));
    checkOutput("post_reset_results", 32'(resCnt - r0), 32'(NPAIRS));
    checkOutput("post_reset_final_err", 32'(bus.err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
